// File: rtl/sdf_split_1i_2o.sv
// sdf_split_1i_2o: SDF actor, 1 token in / 1 token out per firing.
// Alternates tokens between flux 0 (even tokens since reset) and
// flux 1 (odd tokens). A token is read from the upstream FIFO, captured
// one cycle later, then written to the selected downstream FIFO.
// Optional build macro SDF_SPLIT_BCAST_EN turns the block into a
// broadcaster: every token is written to both fluxes in the same cycle,
// and only when both downstream FIFOs have room.
module sdf_split_1i_2o #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_empty,
  output logic             in_read,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out0_full,
  output logic             out0_wr,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out1_full,
  output logic             out1_wr,
  output logic [WIDTH-1:0] out1_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_r;
  logic             wr_go;

`ifdef SDF_SPLIT_BCAST_EN
  // Broadcast: the write happens only when both fluxes can accept it.
  always_comb begin
    wr_go = !out0_full && !out1_full;
  end
`else
  logic sel;

  // Alternating: only the selected flux's full matters; the other one
  // is ignored so the alternation order can never be skipped.
  always_comb begin
    wr_go = sel ? !out1_full : !out0_full;
  end

  // Destination selector flips after every completed write.
  always_ff @(posedge ck) begin
    if (!rst) begin
      sel <= 1'b0;
    end else if (state == WR && wr_go) begin
      // NOTE: state registers use non-blocking assignments so every
      // always_ff sees pre-edge values regardless of evaluation order.
      sel <= ~sel;
    end
  end
`endif

  // State register.
  always_ff @(posedge ck) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch
    // is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (!in_empty) state_nxt = CAP;
      CAP:  state_nxt = WR;
      WR: begin
        if (wr_go) begin
          state_nxt = in_empty ? IDLE : CAP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe outputs: combinational from state, selector and fulls.
  always_comb begin
    in_read = 1'b0;
    out0_wr = 1'b0;
    out1_wr = 1'b0;
    unique case (state)
      IDLE: in_read = !in_empty;
      WR: begin
        if (wr_go) begin
          in_read = !in_empty;
`ifdef SDF_SPLIT_BCAST_EN
          out0_wr = 1'b1;
          out1_wr = 1'b1;
`else
          out0_wr = !sel;
          out1_wr = sel;
`endif
        end
      end
      default: ;
    endcase
  end

  // Token capture: in_data is valid the cycle after in_read, i.e. in CAP.
  always_ff @(posedge ck) begin
    if (!rst) begin
      // NOTE: data_r is a single register, not a memory, so clearing it
      // on reset is cheap and gives deterministic output data.
      data_r <= '0;
    end else if (state == CAP) begin
      data_r <= in_data;
    end
  end

  assign out0_data = data_r;
  assign out1_data = data_r;

endmodule

// File: tb/tb_sdf_split_1i_2o.sv
// Testbench for sdf_split_1i_2o. Upstream FIFO and downstream fluxes are
// modelled with queues; a scoreboard assigns the k-th token read since
// reset to flux k%2 (or to both fluxes when SDF_SPLIT_BCAST_EN is set).
module tb_sdf_split_1i_2o;

  localparam int WIDTH = 8;

  logic             ck;
  logic             rst;
  logic             in_empty;
  logic             in_read;
  logic [WIDTH-1:0] in_data;
  logic             out0_full;
  logic             out0_wr;
  logic [WIDTH-1:0] out0_data;
  logic             out1_full;
  logic             out1_wr;
  logic [WIDTH-1:0] out1_data;

  sdf_split_1i_2o #(.WIDTH(WIDTH)) dut (
    .ck        (ck),
    .rst       (rst),
    .in_empty  (in_empty),
    .in_read   (in_read),
    .in_data   (in_data),
    .out0_full (out0_full),
    .out0_wr   (out0_wr),
    .out0_data (out0_data),
    .out1_full (out1_full),
    .out1_wr   (out1_wr),
    .out1_data (out1_data)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int pop_cnt = 0;
  bit hold_empty = 1'b0;

  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];
  logic [WIDTH-1:0] got0[$];
  logic [WIDTH-1:0] got1[$];
  int               wr_cyc[$];

  // Values sampled in the most recent step.
  logic             s_rd, s_w0, s_w1;
  logic [WIDTH-1:0] s_d0, s_d1;

  task automatic update_empty();
    in_empty = hold_empty || (src_q.size() == 0);
  endtask

  task automatic push_tok(input logic [WIDTH-1:0] v);
    src_q.push_back(v);
    update_empty();
  endtask

  task automatic clear_model();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    wr_cyc.delete();
    pop_cnt = 0;
  endtask

  // One clock cycle: sample and check at negedge, then advance the
  // upstream FIFO model just after the rising edge.
  task automatic step();
    logic [WIDTH-1:0] e;
    @(negedge ck);
    s_rd = in_read; s_w0 = out0_wr; s_w1 = out1_wr;
    s_d0 = out0_data; s_d1 = out1_data;
    checks++;
    if ((s_rd && in_empty) || (s_w0 && out0_full) || (s_w1 && out1_full)) begin
      errors++;
      $display("FAIL protocol cyc=%0d: rd=%b empty=%b w0=%b full0=%b w1=%b full1=%b",
               cycle, s_rd, in_empty, s_w0, out0_full, s_w1, out1_full);
    end
    checks++;
    if (s_d0 !== s_d1) begin
      errors++;
      $display("FAIL data_eq cyc=%0d: out0_data=%0h out1_data=%0h", cycle, s_d0, s_d1);
    end
`ifdef SDF_SPLIT_BCAST_EN
    checks++;
    if (s_w0 !== s_w1) begin
      errors++;
      $display("FAIL bcast_pair cyc=%0d: w0=%b w1=%b", cycle, s_w0, s_w1);
    end
`else
    checks++;
    if (s_w0 && s_w1) begin
      errors++;
      $display("FAIL one_hot cyc=%0d: both writes high", cycle);
    end
`endif
    if (s_w0) begin
      checks++;
      got0.push_back(s_d0);
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL flux0_unexpected cyc=%0d: got=%0d expected none", cycle, s_d0);
      end else begin
        e = exp0.pop_front();
        if (s_d0 !== e) begin
          errors++;
          $display("FAIL flux0_data cyc=%0d: got=%0d expected=%0d", cycle, s_d0, e);
        end
      end
    end
    if (s_w1) begin
      checks++;
      got1.push_back(s_d1);
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL flux1_unexpected cyc=%0d: got=%0d expected none", cycle, s_d1);
      end else begin
        e = exp1.pop_front();
        if (s_d1 !== e) begin
          errors++;
          $display("FAIL flux1_data cyc=%0d: got=%0d expected=%0d", cycle, s_d1, e);
        end
      end
    end
    if (s_w0 || s_w1) wr_cyc.push_back(cycle);
    @(posedge ck);
    #1;
    if (s_rd && rst && src_q.size() > 0) begin
      e = src_q.pop_front();
      in_data = e;
`ifdef SDF_SPLIT_BCAST_EN
      exp0.push_back(e);
      exp1.push_back(e);
`else
      if (pop_cnt % 2 == 0) exp0.push_back(e);
      else exp1.push_back(e);
`endif
      pop_cnt++;
    end
    update_empty();
    cycle++;
  endtask

  task automatic do_reset();
    out0_full = 1'b1;
    out1_full = 1'b1;
    hold_empty = 1'b1;
    update_empty();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    src_q.delete();
    clear_model();
    out0_full = 1'b0;
    out1_full = 1'b0;
    hold_empty = 1'b0;
    update_empty();
  endtask

  // Step until flux `which` has received n tokens, bounded by budget.
  task automatic wait_got(input int which, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (((which == 0) ? got0.size() : got1.size()) < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (((which == 0) ? got0.size() : got1.size()) < n) begin
      errors++;
      $display("FAIL %s_timeout: flux%0d got %0d tokens, required %0d",
               name, which, (which == 0) ? got0.size() : got1.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (s_rd !== 1'b0 || s_w0 !== 1'b0 || s_w1 !== 1'b0 || s_d0 !== '0) begin
      errors++;
      $display("FAIL reset_state: rd=%b w0=%b w1=%b d0=%0h, required 0 0 0 0",
               s_rd, s_w0, s_w1, s_d0);
    end
  endtask

  task automatic test_empty();
    do_reset();
    hold_empty = 1'b1;
    update_empty();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (s_rd || s_w0 || s_w1) begin
        errors++;
        $display("FAIL empty_idle cyc=%0d: rd=%b w0=%b w1=%b, required 0", cycle, s_rd, s_w0, s_w1);
      end
    end
    // Still idle: a token is read in the very first cycle it is offered.
    hold_empty = 1'b0;
    push_tok(8'd42);
    step();
    checks++;
    if (s_rd !== 1'b1) begin
      errors++;
      $display("FAIL empty_wake: in_read=%b required 1", s_rd);
    end
    wait_got(0, 1, 10, "empty_wake");
  endtask

`ifndef SDF_SPLIT_BCAST_EN
  task automatic test_basic();
    do_reset();
    for (int v = 1; v <= 4; v++) push_tok(v[WIDTH-1:0]);
    wait_got(1, 2, 40, "basic");
    checks++;
    if (got0.size() != 2 || got1.size() != 2 ||
        got0[0] != 8'd1 || got0[1] != 8'd3 || got1[0] != 8'd2 || got1[1] != 8'd4) begin
      errors++;
      $display("FAIL basic_order: flux0 n=%0d flux1 n=%0d, required 1,3 and 2,4",
               got0.size(), got1.size());
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[i] - wr_cyc[i-1] != 2) begin
        errors++;
        $display("FAIL basic_gap: write %0d gap=%0d required 2", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int v = 1; v <= 3; v++) push_tok(v[WIDTH-1:0]);
    wait_got(0, 1, 20, "stall_first");
    out1_full = 1'b1;
    // One CAP cycle for token 2, then five stalled WR cycles.
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_rd || s_w0 || s_w1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: rd=%b w0=%b w1=%b, required 0", cycle, s_rd, s_w0, s_w1);
      end
    end
    out1_full = 1'b0;
    step();
    checks++;
    if (s_w1 !== 1'b1 || s_d1 !== 8'd2) begin
      errors++;
      $display("FAIL stall_release: w1=%b data=%0d, required 1 and 2", s_w1, s_d1);
    end
    wait_got(0, 2, 20, "stall_next");
    checks++;
    if (got0.size() < 2 || got0[1] !== 8'd3) begin
      errors++;
      $display("FAIL stall_next_flux0: flux0 second token wrong or missing, required 3");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_tok(8'd6);
    push_tok(8'd7);
    out1_full = 1'b1;
    wait_got(0, 1, 20, "rstmid_first");
    step();   // CAP for token 7
    step();   // WR, stalled on flux 1
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_model();
    out1_full = 1'b0;
    step();
    checks++;
    if (s_rd || s_w0 || s_w1) begin
      errors++;
      $display("FAIL rstmid_after: rd=%b w0=%b w1=%b, required 0", s_rd, s_w0, s_w1);
    end
    push_tok(8'd8);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (got0.size() != 1 || got0[0] !== 8'd8 || got1.size() != 0) begin
      errors++;
      $display("FAIL rstmid_result: flux0 n=%0d flux1 n=%0d, required token 8 on flux0 only",
               got0.size(), got1.size());
    end
  endtask
`else
  task automatic test_bcast();
    do_reset();
    out0_full = 1'b1;
    push_tok(8'd5);
    push_tok(8'd6);
    step();   // IDLE read
    step();   // CAP
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_rd || s_w0 || s_w1) begin
        errors++;
        $display("FAIL bcast_hold cyc=%0d: rd=%b w0=%b w1=%b, required 0", cycle, s_rd, s_w0, s_w1);
      end
    end
    out0_full = 1'b0;
    step();
    checks++;
    if (!(s_w0 && s_w1 && s_d0 == 8'd5)) begin
      errors++;
      $display("FAIL bcast_first: w0=%b w1=%b data=%0d, required 1 1 5", s_w0, s_w1, s_d0);
    end
    step();
    step();
    checks++;
    if (!(s_w0 && s_w1 && s_d0 == 8'd6)) begin
      errors++;
      $display("FAIL bcast_second: w0=%b w1=%b data=%0d, required 1 1 6", s_w0, s_w1, s_d0);
    end
  endtask
`endif

  task automatic test_random();
    int k;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) push_tok(WIDTH'($urandom));
      hold_empty = ($urandom_range(0, 3) == 0);
      update_empty();
      out0_full = ($urandom_range(0, 2) == 0);
      out1_full = ($urandom_range(0, 2) == 0);
      step();
    end
    hold_empty = 1'b0;
    out0_full = 1'b0;
    out1_full = 1'b0;
    update_empty();
    k = 0;
    while ((src_q.size() > 0 || exp0.size() > 0 || exp1.size() > 0 || pop_cnt == 0) && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (src_q.size() != 0 || exp0.size() != 0 || exp1.size() != 0 || pop_cnt == 0) begin
      errors++;
      $display("FAIL random_drain: src=%0d pend0=%0d pend1=%0d popped=%0d, required all delivered",
               src_q.size(), exp0.size(), exp1.size(), pop_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0;
    out0_full = 1'b1;
    out1_full = 1'b1;
    in_empty = 1'b1;
    test_reset();
    test_empty();
`ifndef SDF_SPLIT_BCAST_EN
    test_basic();
    test_stall();
    test_reset_mid();
`else
    test_bcast();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdf_split_1i_2o.md
SDF_SPLIT_1I_2O -- requirements
Module: sdf_split_1i_2o

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the token data width in bits.
REQ-002 The block SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port in_empty, input, 1 bit: the upstream FIFO port is empty.
REQ-005 The block SHALL have port in_read, output, 1 bit: read strobe to the upstream FIFO port.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: upstream FIFO data, valid one cycle after in_read.
REQ-007 The block SHALL have port out0_full, input, 1 bit: downstream flux 0 FIFO is full.
REQ-008 The block SHALL have port out0_wr, output, 1 bit: write strobe to flux 0.
REQ-009 The block SHALL have port out0_data, output, WIDTH bits: token for flux 0.
REQ-010 The block SHALL have port out1_full, input, 1 bit: downstream flux 1 FIFO is full.
REQ-011 The block SHALL have port out1_wr, output, 1 bit: write strobe to flux 1.
REQ-012 The block SHALL have port out1_data, output, WIDTH bits: token for flux 1.

Function
REQ-013 The block SHALL act as an SDF actor consuming 1 token per firing and producing 1 token, alternating between outputs: input token 2k goes to flux 0 and token 2k+1 goes to flux 1, counted from reset.
REQ-014 The block SHALL use the states IDLE, CAP and WR, plus a 1-bit destination selector sel and a WIDTH-bit data register data_r.
REQ-015 In IDLE with in_empty=0, the block SHALL assert in_read=1 for exactly that cycle and go to CAP; with in_empty=1 it SHALL stay in IDLE with all strobes 0.
REQ-016 In CAP, the block SHALL load data_r from in_data, keep all strobes 0, and go to WR.
REQ-017 In WR with the selected output's full=0, the block SHALL assert that output's wr for 1 cycle (combinational from state, sel and full) and toggle sel.
REQ-018 In the same WR write cycle, if in_empty=0 the block SHALL also assert in_read and go to CAP; otherwise it SHALL go to IDLE; sustained throughput is therefore 1 token per 2 cycles.
REQ-019 In WR with the selected output's full=1, the block SHALL stall: state, sel and data_r held, and in_read, out0_wr and out1_wr all 0.
REQ-020 The non-selected output's full SHALL have no effect on the decision in WR (no skipping ahead of the alternation order).
REQ-021 out0_data and out1_data SHALL both equal data_r at all times.
REQ-022 The block SHALL never assert in_read while in_empty=1, and never assert outN_wr while outN_full=1.
REQ-023 At most one of out0_wr and out1_wr SHALL be high in any cycle, except in broadcast mode.

Reset
REQ-024 When rst=0 at a rising edge of ck, the block SHALL reset state to IDLE, sel to 0 and data_r to 0; in the following cycle in_read, out0_wr and out1_wr SHALL be 0.
REQ-025 A reset in CAP or WR SHALL discard the held token, and the first token after reset SHALL go to flux 0.

Configuration
REQ-026 With macro SDF_SPLIT_BCAST_EN defined, the block SHALL run in broadcast mode: in WR it writes only when out0_full=0 and out1_full=0, asserts out0_wr and out1_wr in the same cycle, and does not use sel.
REQ-027 With SDF_SPLIT_BCAST_EN undefined, the block SHALL use the alternating behaviour of REQ-013 to REQ-023, and the broadcast logic SHALL be absent.

Verification
REQ-028 Load 1,2,3,4 into the upstream FIFO with both fulls low -> flux 0 receives 1,3 and flux 1 receives 2,4; consecutive writes are exactly 2 cycles apart.
REQ-029 Hold out1_full=1 for 5 cycles while token 2 is in WR -> out1_wr, out0_wr and in_read stay 0 for 5 cycles; 2 is written the cycle after out1_full falls, and token 3 still goes to flux 0.
REQ-030 Hold in_empty=1 throughout -> in_read, out0_wr and out1_wr stay 0 and the state stays IDLE.
REQ-031 Pulse rst=0 for 1 cycle while token 7 is in WR (sel=1), then supply token 8 -> 7 is never written and 8 appears on flux 0.
REQ-032 Build with SDF_SPLIT_BCAST_EN and supply 5,6 with out0_full=1 for 3 cycles -> no writes during those cycles, then out0_wr=out1_wr=1 with data 5, then the same with data 6.
REQ-033 Throughout all scenarios, check that there is no in_read while in_empty=1 and no outN_wr while outN_full=1.
